// File: rtl/usart_pkg.sv
// usart_pkg: definitions shared by the USART receiver and transmitter.
//   rx_state_t           - receiver FSM states
//   CLKS_PER_BIT_DEFAULT - default clock cycles per serial bit
//   DATA_BITS            - data bits per frame (sent LSB first)
//   START_LEVEL          - line level of the start bit
//   STOP_LEVEL           - line level of the stop bit (also the idle level)
package usart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned DATA_BITS            = 8;
    localparam logic        START_LEVEL          = 1'b0;
    localparam logic        STOP_LEVEL           = 1'b1;

endpackage

// File: rtl/usart_rx_sync.sv
// usart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Both flops reset to 1 so a reset never looks like a start bit.
//   clk      - receiver clock
//   rst_n    - asynchronous active-low reset
//   async_in - raw serial line
//   sync_out - line value synchronized to clk
module usart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/usart_rx.sv
// usart_rx: 8N1 serial receiver with valid/ack output handshake.
//   CLK        - clock, all state changes on the rising edge
//   CLR        - asynchronous active-low reset
//   SERIAL_IN  - asynchronous serial line, idle high
//   DATA_OUT   - last correctly framed byte (bit i = Di)
//   DATA_VALID - DATA_OUT holds an unacknowledged byte
//   DATA_ACK   - consumer accepts DATA_OUT
//   FRAME_ERR  - one-cycle pulse when the stop bit samples 0
//   OVERRUN    - sticky: a byte was overwritten before being acknowledged
//   BUSY       - receiver FSM is not idle
module usart_rx
    import usart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       SERIAL_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    input  logic       DATA_ACK,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    rx_state_t        state;
    logic             rx;
    logic             rx_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             byte_done;

    usart_rx_sync u_sync (
        .clk      (CLK),
        .rst_n    (CLR),
        .async_in (SERIAL_IN),
        .sync_out (rx)
    );

    assign BUSY = (state != ST_IDLE);

    // Frame FSM. byte_done is a one-cycle strobe after a good stop bit; the
    // assembled byte stays in shift_reg until the next frame's data phase.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state     <= ST_IDLE;
            rx_prev   <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            byte_done <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            rx_prev   <= rx;
            byte_done <= 1'b0;
            FRAME_ERR <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_cnt == CNT_MID) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= (rx == START_LEVEL) ? ST_DATA : ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx, shift_reg[7:1]};
                        if (bit_idx == BIT_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        if (rx == STOP_LEVEL) begin
                            byte_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx == STOP_LEVEL) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output handshake: a completing byte always wins over an ack in the
    // same cycle, so the ack is consumed by the old byte and the new one
    // stays valid without flagging overrun.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (byte_done) begin
            DATA_OUT   <= shift_reg;
            DATA_VALID <= 1'b1;
            if (DATA_VALID && !DATA_ACK) begin
                OVERRUN <= 1'b1;
            end
        end else if (DATA_ACK) begin
            DATA_VALID <= 1'b0;
        end
    end

endmodule

// File: doc/usart_rx.md
USART_RX -- requirements
Module: usart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: CLK cycles per serial bit; legal values are even and 4..1024.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port CLR, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port SERIAL_IN, input, 1 bit: asynchronous serial line, idle high; frame = 1 start bit (0), 8 data bits LSB first (D0..D7), 1 stop bit (1).
REQ-005 SHALL have port DATA_OUT, output, 8 bits: last correctly framed byte; bit i = Di.
REQ-006 SHALL have port DATA_VALID, output, 1 bit: DATA_OUT holds an unacknowledged byte.
REQ-007 SHALL have port DATA_ACK, input, 1 bit: consumer accepts DATA_OUT; sampled every cycle.
REQ-008 SHALL have port FRAME_ERR, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-009 SHALL have port OVERRUN, output, 1 bit: sticky; a byte was lost.
REQ-010 SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass SERIAL_IN through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: SHALL move to START on a synchronized 1->0 transition and clear the bit-timing counter.
REQ-014 START: SHALL sample at count CLKS_PER_BIT/2-1; a sample of 0 moves to DATA, a sample of 1 (glitch) returns to IDLE with no output change.
REQ-015 DATA: SHALL sample every CLKS_PER_BIT cycles after the start mid-point and shift into an 8-bit register LSB first; after the 8th sample it SHALL move to STOP.
REQ-016 STOP: SHALL sample CLKS_PER_BIT cycles after the 8th data sample; a sample of 1 loads DATA_OUT, sets DATA_VALID the next cycle, and returns to IDLE.
REQ-017 A stop sample of 0 SHALL pulse FRAME_ERR for exactly 1 cycle, SHALL leave DATA_OUT and DATA_VALID unchanged, and SHALL enter BREAK.
REQ-018 BREAK: SHALL stay until the synchronized line is 1, then go to IDLE; no start is detected while in BREAK.
REQ-019 DATA_VALID SHALL clear on the cycle after DATA_ACK=1; DATA_ACK while DATA_VALID=0 SHALL be ignored.
REQ-020 If a new byte completes while DATA_VALID=1 and DATA_ACK=0: DATA_OUT SHALL take the new byte, DATA_VALID SHALL stay 1, and OVERRUN SHALL set.
REQ-021 If a new byte completes in the same cycle as DATA_ACK=1: the new byte SHALL load, DATA_VALID SHALL stay 1, and OVERRUN SHALL not set.
REQ-022 OVERRUN SHALL clear only on reset.
REQ-023 Latency: DATA_VALID SHALL rise 1 cycle after the stop-bit sample edge, i.e. about 9.5*CLKS_PER_BIT+3 cycles after the start falling edge reaches the pin.
REQ-024 The bit-timing counter SHALL be clog2(CLKS_PER_BIT) bits wide, SHALL wrap at CLKS_PER_BIT-1, and the bit index SHALL be 3 bits.

Reset
REQ-025 CLR=0 SHALL asynchronously force: FSM=IDLE, counters=0, synchronizer=1, DATA_OUT=0x00, DATA_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a fresh 1->0 edge.

Structure
REQ-027 Shared package usart_pkg SHALL hold the FSM state type, the default CLKS_PER_BIT, and the frame constants (DATA_BITS=8, START_LEVEL=0, STOP_LEVEL=1), shared with the transmitter.
REQ-028 The synchronizer SHALL be a sub-module, usart_rx_sync (2-flop, reset-to-1).

Verification (CLKS_PER_BIT=16)
REQ-029 Send frame 0x0B with DATA_ACK held 0 -> DATA_OUT=0x0B, DATA_VALID=1 within 156..158 cycles of the start edge, FRAME_ERR=0, OVERRUN=0.
REQ-030 Drive a 4-cycle low glitch on an idle line -> FSM returns to IDLE, BUSY high for at most 10 cycles, DATA_VALID stays 0.
REQ-031 Send 0xA5 with the stop bit forced to 0 -> one FRAME_ERR pulse, DATA_VALID stays 0, BUSY held until the line returns to 1.
REQ-032 Send 0x11 then 0x22 back-to-back with no ack -> DATA_OUT=0x22, OVERRUN=1; then ack with the 0x33 completion in the same cycle -> DATA_VALID=1, DATA_OUT=0x33.
REQ-033 Assert CLR=0 during bit D4 of 0xFF, then release and send 0x3C -> only 0x3C is delivered, and all outputs are at reset values while CLR=0.
